// File: rtl/sand_row_stream.sv
// Streaming sand gravity step over a region/floor row pair, one packed word per cycle.
// Optional floor spout injection is enabled by defining SAND_SPOUT_EN.
module sand_row_stream #(
    parameter int CELLS = 16,
    parameter int WORDS = 40
`ifdef SAND_SPOUT_EN
    ,
    parameter int SPOUT_WORD = WORDS / 2
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_row_bottom,
    input  logic                 i_flip,
`ifdef SAND_SPOUT_EN
    input  logic                 i_spout,
`endif
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [2*CELLS-1:0]   i_in_region,
    input  logic [2*CELLS-1:0]   i_in_floor,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*CELLS-1:0]   o_out_region,
    output logic [2*CELLS-1:0]   o_out_floor,
    output logic                 o_out_last,
    output logic                 o_busy
);
    localparam int W  = 2 * CELLS;
    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    localparam logic [1:0] AIR = 2'b00, SAND = 2'b01, SAND_AM = 2'b10, WALL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2} state_t;

    typedef struct packed {
        logic [W-1:0] region;
        logic [W-1:0] floor;
        logic         wr_left;
        logic         wr_right;
    } proc_t;

    // Scans one word left to right; left/right are the neighbouring floor cells outside the word.
    function automatic proc_t proc_word(input logic [W-1:0] region, input logic [W-1:0] floor,
                                        input logic [1:0] left, input logic [1:0] right,
                                        input logic odd, input logic flip);
        logic [1:0] f [0:CELLS+1];
        logic [1:0] r;
        logic       par;
        proc_t      res;
        res = '0;
        f[0]       = left;
        f[CELLS+1] = right;
        for (int j = 0; j < CELLS; j++) f[j+1] = floor[2*(CELLS-1-j) +: 2];
        for (int j = 0; j < CELLS; j++) begin
            r   = region[2*(CELLS-1-j) +: 2];
            par = (((CELLS % 2) == 1) && odd) ^ j[0];
            if (r == SAND) begin
                if (f[j+1] == AIR) begin
                    f[j+1] = SAND_AM;
                    r      = AIR;
                end else if (f[j] == AIR && f[j+2] == AIR) begin
                    if (par ^ flip) f[j+2] = SAND_AM;
                    else            f[j]   = SAND_AM;
                    r = AIR;
                end else if (f[j] == AIR) begin
                    f[j] = SAND_AM;
                    r    = AIR;
                end else if (f[j+2] == AIR) begin
                    f[j+2] = SAND_AM;
                    r      = AIR;
                end
            end else if (r == SAND_AM) begin
                r = SAND;
            end
            res.region[2*(CELLS-1-j) +: 2] = r;
        end
        for (int j = 0; j < CELLS; j++) res.floor[2*(CELLS-1-j) +: 2] = f[j+1];
        res.wr_left  = (f[0] != left);
        res.wr_right = (f[CELLS+1] != right);
        return res;
    endfunction

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_bottom, r_flip, r_busy;
    logic [W-1:0]    r_o_region, r_o_floor, r_p_region, r_p_floor, r_c_region, r_c_floor;
    logic            r_o_valid, r_o_last, r_p_valid, r_c_valid, r_c_odd;

    logic            w_start, w_acc, w_o_free, w_step1, w_step2, w_shift;
    logic [W-1:0]    w_in_floor, w_p_floor_fix, w_in_floor_fix;
    logic [1:0]      w_left, w_right;
    proc_t           w_proc;

    assign w_start    = (r_state == S_IDLE) && i_start;
    assign w_o_free   = !r_o_valid || i_out_ready;
    assign o_in_ready = (r_state == S_RUN) && w_o_free;
    assign w_acc      = i_in_valid && o_in_ready;
    assign w_step1    = (r_state == S_DRAIN1) && w_o_free;
    assign w_step2    = (r_state == S_DRAIN2) && w_o_free;
    assign w_shift    = w_acc || w_step1 || w_step2;

    // A bottom row turns the whole floor into WALL before any physics sees it.
    assign w_in_floor = r_bottom ? '1 : i_in_floor;
    assign w_left     = r_p_valid ? r_p_floor[1:0] : WALL;
    assign w_right    = (r_state == S_DRAIN1) ? WALL : w_in_floor[W-1 -: 2];
    assign w_proc     = proc_word(r_c_region, r_c_floor, w_left, w_right, r_c_odd, r_flip);

    assign w_p_floor_fix  = {r_p_floor[W-1:2],
                             (w_proc.wr_left && r_c_valid) ? SAND_AM : r_p_floor[1:0]};
    assign w_in_floor_fix = {(w_proc.wr_right && r_c_valid) ? SAND_AM : w_in_floor[W-1 -: 2],
                             w_in_floor[W-3:0]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_RUN;
            S_RUN:    if (w_acc && r_cnt == LAST) w_state_nxt = S_DRAIN1;
            S_DRAIN1: if (w_o_free) w_state_nxt = S_DRAIN2;
            S_DRAIN2: if (w_o_free) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_bottom   <= 1'b0;
            r_flip     <= 1'b0;
            r_busy     <= 1'b0;
            r_o_region <= '0;
            r_o_floor  <= '0;
            r_o_valid  <= 1'b0;
            r_o_last   <= 1'b0;
            r_p_region <= '0;
            r_p_floor  <= '0;
            r_p_valid  <= 1'b0;
            r_c_region <= '0;
            r_c_floor  <= '0;
            r_c_valid  <= 1'b0;
            r_c_odd    <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt    <= '0;
                r_bottom <= i_row_bottom;
                r_flip   <= i_flip;
                r_busy   <= 1'b1;
            end else begin
                if (w_acc && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
                if (r_o_valid && r_o_last && i_out_ready) r_busy <= 1'b0;
            end

            if (w_shift) begin
                r_o_region <= r_p_region;
                r_o_floor  <= w_p_floor_fix;
                r_o_valid  <= r_p_valid;
                r_o_last   <= w_step2;
                r_p_region <= w_proc.region;
                r_p_floor  <= w_proc.floor;
                r_p_valid  <= r_c_valid;
                if (w_acc) begin
                    r_c_region <= i_in_region;
                    r_c_floor  <= w_in_floor_fix;
                    r_c_valid  <= 1'b1;
                    r_c_odd    <= r_cnt[0];
                end else begin
                    r_c_valid  <= 1'b0;
                end
            end else if (r_o_valid && i_out_ready) begin
                r_o_valid <= 1'b0;
                r_o_last  <= 1'b0;
            end
        end
    end

    assign o_out_valid  = r_o_valid;
    assign o_out_region = r_o_region;
    assign o_out_last   = r_o_last;
    assign o_busy       = r_busy;

`ifdef SAND_SPOUT_EN
    logic          r_spout;
    logic [CW-1:0] r_o_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_spout <= 1'b0;
            r_o_idx <= '0;
        end else begin
            if (w_start) r_spout <= i_spout;
            if (r_o_valid && i_out_ready) r_o_idx <= r_o_last ? '0 : r_o_idx + 1'b1;
        end
    end

    always_comb begin
        o_out_floor = r_o_floor;
        if (r_spout && !r_bottom && r_o_idx == CW'(SPOUT_WORD)) begin
            for (int k = 0; k < CELLS; k++)
                if (r_o_floor[2*k +: 2] == AIR) o_out_floor[2*k +: 2] = SAND;
        end
    end
`else
    assign o_out_floor = r_o_floor;
`endif

endmodule
